// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register-bank completer.
package apb_slave_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Lanes with a set strobe take the new byte; others keep the old one.
  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB4 bus bundle between a requester and the register-bank completer.
interface apb_slave_regbank_if
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH
);
  logic                      PSELx;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_reg_mem.sv
// Word storage with per-byte write enables, async clear and one combinational read port.
module apb_reg_mem
  import apb_slave_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [AW-1:0]           ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] merged_s;

  // Narrow buses are widened to the helper's 32-bit view and cut back
  always_comb begin
    merged_s = DATA_WIDTH'(strb_merge(32'(mem_r[widx]), 32'(wdata), 4'(wstrb)));
  end

  // Storage update and asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_r[widx] <= merged_s;
    end
  end

  // Read port, guarded for non-power-of-two depths
  always_comb begin
    if (int'(ridx) < DEPTH) begin
      rdata = mem_r[ridx];
    end else begin
      rdata = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB4 completer: word-addressed register bank with wait states, byte strobes,
// a read-only top region and PSLVERR on bad accesses.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_slave_regbank_if.slave bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_C   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] RO_BASE_C = (IDX_W+1)'(DEPTH - RO_WORDS);
  localparam logic [3:0]     WAIT_C    = 4'(WAIT_STATES);

  apb_state_e             state_r;
  apb_state_e             next_s;
  logic [3:0]             cnt_r;
  logic [MEM_AW-1:0]      midx_r;
  logic                   write_r;
  logic                   err_r;
  logic                   load_s;
  logic                   enter_access_s;
  logic                   commit_s;
  logic                   misalign_s;
  logic                   err_s;
  logic [IDX_W-1:0]       idx_s;
  logic [DATA_WIDTH-1:0]  rdata_s;
  logic [DATA_WIDTH-1:0]  prdata_r;
  logic                   pready_r;
  logic                   pslverr_r;

  assign idx_s = bus.PADDR[ADDR_WIDTH-1:OFF_W];

  if (OFF_W > 0) begin : g_align
    assign misalign_s = |bus.PADDR[OFF_W-1:0];
  end else begin : g_noalign
    assign misalign_s = 1'b0;
  end

  // Error decode on the setup-phase address and direction
  always_comb begin
    err_s = misalign_s
         || ({1'b0, idx_s} >= DEPTH_C)
         || (bus.PWRITE && ({1'b0, idx_s} >= RO_BASE_C));
  end

  // Next-state logic; dropping PSELx mid-transfer abandons it
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.PSELx && !bus.PENABLE) begin
          next_s = ST_WAIT;
          load_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.PSELx) begin
          next_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          next_s = ST_ACCESS;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_ACCESS: next_s = ST_IDLE;
      default:   next_s = ST_IDLE;
    endcase
  end

  // Write commits at the completing edge only if still selected and legal
  always_comb begin
    enter_access_s = (state_r == ST_WAIT) && (next_s == ST_ACCESS);
    if ((state_r == ST_ACCESS) && bus.PSELx && write_r && !err_r) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // State register, wait counter and latched transfer attributes
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      midx_r  <= {MEM_AW{1'b0}};
      write_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      if (load_s) begin
        cnt_r   <= WAIT_C;
        midx_r  <= idx_s[MEM_AW-1:0];
        write_r <= bus.PWRITE;
        err_r   <= err_s;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Response registers, valid only during the single ACCESS cycle
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      pready_r  <= enter_access_s;
      pslverr_r <= enter_access_s && err_r;
      if (enter_access_s && !err_r && !write_r) begin
        prdata_r <= rdata_s;
      end else begin
        prdata_r <= {DATA_WIDTH{1'b0}};
      end
    end
  end

  apb_reg_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (MEM_AW)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (PRESET),
    .we    (commit_s),
    .widx  (midx_r),
    .wdata (bus.PWDATA),
    .wstrb (bus.PSTRB),
    .ridx  (midx_r),
    .rdata (rdata_s)
  );

  assign bus.PRDATA  = prdata_r;
  assign bus.PREADY  = pready_r;
  assign bus.PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Drives three differently configured register banks through a shared requester
// and compares every response with an array-based reference model.
module tb_apb_slave_regbank;

  localparam int WS [3] = '{0, 3, 2};
  localparam int RO [3] = '{0, 2, 0};

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          sel;

  logic        rdy_v [3];
  logic        err_v [3];
  logic [31:0] rd_v  [3];

  logic [31:0] mem_m [3][16];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 pclk = ~pclk;

  apb_slave_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].PSELx   = psel && (sel == g);
    assign bus[g].PENABLE = penable;
    assign bus[g].PWRITE  = pwrite;
    assign bus[g].PADDR   = paddr;
    assign bus[g].PWDATA  = pwdata;
    assign bus[g].PSTRB   = pstrb;
    assign rdy_v[g]       = bus[g].PREADY;
    assign err_v[g]       = bus[g].PSLVERR;
    assign rd_v[g]        = bus[g].PRDATA;
  end

  apb_slave_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0), .RO_WORDS(0))
    dut_a (.PCLK(pclk), .PRESET(preset_n), .bus(bus[0]));
  apb_slave_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(3), .RO_WORDS(2))
    dut_b (.PCLK(pclk), .PRESET(preset_n), .bus(bus[1]));
  apb_slave_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(2), .RO_WORDS(0))
    dut_c (.PCLK(pclk), .PRESET(preset_n), .bus(bus[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input int d, input bit wr, input logic [7:0] a);
    int idx;
    idx = int'(a[7:2]);
    return (a[1:0] != 2'b00) || (idx >= 16) || (wr && (idx >= 16 - RO[d]));
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++)
        mem_m[d][w] = 32'h0;
  endtask

  // One full transfer on bank d; checks latency, PSLVERR and PRDATA against the model
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input string tag);
    bit          e;
    logic [31:0] er;
    int          n;
    e = exp_err(d, wr, a);
    if (!e && !wr) er = mem_m[d][a[5:2]];
    else           er = 32'h0;
    @(negedge pclk);
    chk({tag, " ready-idle"}, {31'h0, rdy_v[d]}, 32'h0);
    sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge pclk);
    penable = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!rdy_v[d] && n < 40);
    chk({tag, " latency"}, 32'(n), 32'(1 + WS[d]));
    chk({tag, " pslverr"}, {31'h0, err_v[d]}, {31'h0, e});
    chk({tag, " prdata"}, rd_v[d], er);
    if (wr && !e)
      for (int b = 0; b < 4; b++)
        if (st[b]) mem_m[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Asynchronous reset between edges; responses must clear at once
  task automatic rst_now(input int d, input string tag);
    #2 preset_n = 1'b0;
    #1;
    chk({tag, " pready"}, {31'h0, rdy_v[d]}, 32'h0);
    chk({tag, " pslverr"}, {31'h0, err_v[d]}, 32'h0);
    chk({tag, " prdata"}, rd_v[d], 32'h0);
    psel = 1'b0; penable = 1'b0;
    clear_model();
    @(negedge pclk);
    preset_n = 1'b1;
  endtask

  initial begin
    bit          wr;
    int          d, r;
    logic [7:0]  a;
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0; sel = 0;
    clear_model();
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("reset pready", {31'h0, rdy_v[i]}, 32'h0);
      chk("reset pslverr", {31'h0, err_v[i]}, 32'h0);
      chk("reset prdata", rd_v[i], 32'h0);
    end
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;

    // Zero-wait basics and error cases on bank A
    xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, "a wr04");
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, "a rd04");
    chk("a rd04 const", rd_v[0], 32'hDEADBEEF);
    xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, "a rd40 range");
    xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, "a rd05 misalign");
    xfer(0, 1'b1, 8'h06, 32'h12345678, 4'hF, "a wr06 misalign");
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, "a rd04 after bad");

    // Byte strobes
    xfer(0, 1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF, "a wr0c ones");
    xfer(0, 1'b1, 8'h0C, 32'h00000000, 4'b0101, "a wr0c strb");
    xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, "a rd0c");
    chk("a rd0c const", rd_v[0], 32'hFF00FF00);
    xfer(0, 1'b1, 8'h0C, 32'h11111111, 4'h0, "a wr0c nostrb");
    xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, "a rd0c again");

    // Wait states and read-only region on bank B
    xfer(1, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, "b wr08");
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, "b rd08");
    xfer(1, 1'b1, 8'h34, 32'hA1B2C3D4, 4'hF, "b wr34 rw");
    xfer(1, 1'b1, 8'h3C, 32'h55555555, 4'hF, "b wr3c ro");
    xfer(1, 1'b1, 8'h38, 32'h66666666, 4'hF, "b wr38 ro");
    xfer(1, 1'b0, 8'h3C, 32'h0, 4'h0, "b rd3c");
    xfer(1, 1'b0, 8'h34, 32'h0, 4'h0, "b rd34");

    // Abort a write on bank C during WAIT
    @(negedge pclk);
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10;
    pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("c abort pready", {31'h0, rdy_v[2]}, 32'h0);
    end
    xfer(2, 1'b0, 8'h10, 32'h0, 4'h0, "c rd10 after abort");
    chk("c rd10 const", rd_v[2], 32'h0);

    // Reset while a read is in its ACCESS cycle on bank A
    @(negedge pclk);
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    chk("a pre-rst pready", {31'h0, rdy_v[0]}, 32'h1);
    chk("a pre-rst prdata", rd_v[0], 32'hDEADBEEF);
    rst_now(0, "a rst-access");
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, "a rd04 post-rst");
    xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, "a rd0c post-rst");

    // Reset in the middle of WAIT on bank B after earlier writes
    xfer(1, 1'b1, 8'h20, 32'h0BADF00D, 4'hF, "b wr20");
    @(negedge pclk);
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h24;
    pwdata = 32'h77777777; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    rst_now(1, "b rst-wait");
    xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, "b rd20 post-rst");
    xfer(1, 1'b0, 8'h24, 32'h0, 4'h0, "b rd24 post-rst");

    // Randomised traffic across all three banks
    for (int k = 0; k < 60; k++) begin
      d  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 7)       a = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
      else if (r == 7) a = {2'b00, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else             a = 8'($urandom_range(0, 255));
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", k));
    end

    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
